jtdd_snd_romarb: RTL and testbench

Sound-subsystem ROM arbiter. It shares one SDRAM read slot between three requesters: the sound CPU program ROM and the two ADPCM sample ROMs. Each requester has a one-entry cache with a level-style `cs`/`ok` handshake. Requests go to the single downstream slot in priority order. The block sits between the sound section and the SDRAM slot controller, and replaces three separate slots with one.

---
 rtl/jtdd_snd_romarb.sv | 145 ++++++++++++++
 tb/tb_jtdd_snd_romarb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_snd_romarb.sv
// rtl/jtdd_snd_romarb.sv - sound ROM arbiter: three one-entry caches sharing one SDRAM slot
// Define JTDD_SNDARB_RR_EN for round-robin between the two ADPCM channels.
module jtdd_snd_romarb #(
    parameter int            AW         = 18,
    parameter logic [AW-1:0] CPU_OFFSET = AW'(18'h00000),
    parameter logic [AW-1:0] AD0_OFFSET = AW'(18'h08000),
    parameter logic [AW-1:0] AD1_OFFSET = AW'(18'h18000)
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic [14:0]   cpu_addr,
    input  logic          cpu_cs,
    output logic          cpu_ok,
    output logic [7:0]    cpu_data,

    input  logic [15:0]   ad0_addr,
    input  logic          ad0_cs,
    output logic          ad0_ok,
    output logic [7:0]    ad0_data,

    input  logic [15:0]   ad1_addr,
    input  logic          ad1_cs,
    output logic          ad1_ok,
    output logic [7:0]    ad1_data,

    output logic [AW-1:0] slot_addr,
    output logic          slot_req,
    input  logic [7:0]    slot_data,
    input  logic          slot_ok
);

    typedef enum logic { IDLE, BUSY } state_t;
    typedef enum logic [1:0] { GNT_CPU, GNT_AD0, GNT_AD1 } gnt_t;

    state_t      state;
    gnt_t        gnt;
    logic [15:0] tag_lat;

    logic        cpu_valid, ad0_valid, ad1_valid;
    logic [14:0] cpu_tag;
    logic [15:0] ad0_tag, ad1_tag;

    logic        cpu_pend, ad0_pend, ad1_pend;
    logic        sel_ad1;
    logic [AW-1:0] cpu_full, ad0_full, ad1_full;

    // ok is combinational so a changed address drops it in the same cycle
    assign cpu_ok = cpu_cs & cpu_valid & (cpu_tag == cpu_addr);
    assign ad0_ok = ad0_cs & ad0_valid & (ad0_tag == ad0_addr);
    assign ad1_ok = ad1_cs & ad1_valid & (ad1_tag == ad1_addr);

    assign cpu_pend = cpu_cs & ~cpu_ok;
    assign ad0_pend = ad0_cs & ~ad0_ok;
    assign ad1_pend = ad1_cs & ~ad1_ok;

    assign cpu_full = CPU_OFFSET + AW'(cpu_addr);
    assign ad0_full = AD0_OFFSET + AW'(ad0_addr);
    assign ad1_full = AD1_OFFSET + AW'(ad1_addr);

`ifdef JTDD_SNDARB_RR_EN
    logic rr_ad1;   // 1 when AD1 is preferred over AD0

    assign sel_ad1 = ad1_pend & (~ad0_pend | rr_ad1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ad1 <= 1'b0;
        end else if (state == IDLE && !cpu_pend && (ad0_pend || ad1_pend)) begin
            rr_ad1 <= ~sel_ad1;
        end
    end
`else
    assign sel_ad1 = ad1_pend & ~ad0_pend;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= GNT_CPU;
            tag_lat   <= '0;
            slot_addr <= '0;
            slot_req  <= 1'b0;
            cpu_valid <= 1'b0;
            ad0_valid <= 1'b0;
            ad1_valid <= 1'b0;
            cpu_tag   <= '0;
            ad0_tag   <= '0;
            ad1_tag   <= '0;
            cpu_data  <= '0;
            ad0_data  <= '0;
            ad1_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_pend) begin
                        gnt       <= GNT_CPU;
                        tag_lat   <= {1'b0, cpu_addr};
                        slot_addr <= cpu_full;
                        slot_req  <= 1'b1;
                        state     <= BUSY;
                    end else if (sel_ad1) begin
                        gnt       <= GNT_AD1;
                        tag_lat   <= ad1_addr;
                        slot_addr <= ad1_full;
                        slot_req  <= 1'b1;
                        state     <= BUSY;
                    end else if (ad0_pend) begin
                        gnt       <= GNT_AD0;
                        tag_lat   <= ad0_addr;
                        slot_addr <= ad0_full;
                        slot_req  <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // fill with the address latched at grant, not the live one
                    if (slot_ok) begin
                        case (gnt)
                            GNT_CPU: begin
                                cpu_valid <= 1'b1;
                                cpu_tag   <= tag_lat[14:0];
                                cpu_data  <= slot_data;
                            end
                            GNT_AD0: begin
                                ad0_valid <= 1'b1;
                                ad0_tag   <= tag_lat;
                                ad0_data  <= slot_data;
                            end
                            default: begin
                                ad1_valid <= 1'b1;
                                ad1_tag   <= tag_lat;
                                ad1_data  <= slot_data;
                            end
                        endcase
                        slot_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtdd_snd_romarb.sv
// tb/tb_jtdd_snd_romarb.sv - scoreboard bench for jtdd_snd_romarb with a latency-programmable slot responder
module tb_jtdd_snd_romarb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic        cpu_cs = 1'b0;
    logic        cpu_ok;
    logic [7:0]  cpu_data;
    logic [15:0] ad0_addr = '0;
    logic        ad0_cs = 1'b0;
    logic        ad0_ok;
    logic [7:0]  ad0_data;
    logic [15:0] ad1_addr = '0;
    logic        ad1_cs = 1'b0;
    logic        ad1_ok;
    logic [7:0]  ad1_data;
    logic [17:0] slot_addr;
    logic        slot_req;
    logic [7:0]  slot_data = '0;
    logic        slot_ok = 1'b0;

    int passed = 0;
    int total = 0;
    int grants = 0;
    int fills = 0;
    int last_gap = 0;
    int low_cnt = 0;
    int lat = 2;
    bit resp_en = 1'b1;
    int man_req = 0;
    logic [17:0] exp_q[$];

    jtdd_snd_romarb dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_ok(cpu_ok), .cpu_data(cpu_data),
        .ad0_addr(ad0_addr), .ad0_cs(ad0_cs), .ad0_ok(ad0_ok), .ad0_data(ad0_data),
        .ad1_addr(ad1_addr), .ad1_cs(ad1_cs), .ad1_ok(ad1_ok), .ad1_data(ad1_data),
        .slot_addr(slot_addr), .slot_req(slot_req), .slot_data(slot_data), .slot_ok(slot_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] dm(input logic [17:0] a);
        return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'h83;
    endfunction

    function automatic logic ok_of(input int ch);
        case (ch)
            0:       return cpu_ok;
            1:       return ad0_ok;
            default: return ad1_ok;
        endcase
    endfunction

    task automatic wait_ok(input int ch, input string tag);
        for (int n = 0; n < 100 && !ok_of(ch); n++) begin
            @(negedge clk); #1;
        end
        check(tag, ok_of(ch), 1);
    endtask

    task automatic wait_grant(input int target);
        for (int n = 0; n < 100 && grants < target; n++) begin
            @(negedge clk); #1;
        end
        check("grant_seen", grants, target);
    endtask

    task automatic wait_fill(input int target);
        for (int n = 0; n < 100 && fills < target; n++) begin
            @(negedge clk); #1;
        end
        check("fill_seen", fills, target);
    endtask

    // slot model: pops the scoreboard on each grant, answers lat cycles after slot_req rises
    initial begin : responder
        bit prev_req;
        int req_cyc;
        int man_done;
        logic [17:0] e;
        prev_req = 1'b0;
        req_cyc = 0;
        man_done = 0;
        forever begin
            @(negedge clk);
            slot_ok = 1'b0;
            if (!rst_n) begin
                prev_req = 1'b0;
                req_cyc = 0;
            end else begin
                if (slot_req && !prev_req) begin
                    grants++;
                    last_gap = low_cnt;
                    low_cnt = 0;
                    req_cyc = 0;
                    if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        check("grant_addr", slot_addr, e);
                    end
                end
                if (!slot_req) low_cnt++;
                else req_cyc++;
                if (slot_req && resp_en && req_cyc == lat + 1) begin
                    slot_ok = 1'b1;
                    slot_data = dm(slot_addr);
                    fills++;
                end
                prev_req = slot_req;
            end
            if (man_req != man_done) begin
                man_done = man_req;
                slot_ok = 1'b1;
                slot_data = 8'h5A;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        int g0;
        int f0;
        // reset state, with requests present
        cpu_cs = 1'b1; ad0_cs = 1'b1; ad1_cs = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_slot_req", slot_req, 0);
        check("rst_slot_addr", slot_addr, 0);
        check("rst_cpu_ok", cpu_ok, 0);
        check("rst_ad0_ok", ad0_ok, 0);
        check("rst_ad1_ok", ad1_ok, 0);
        check("rst_cpu_data", cpu_data, 0);
        cpu_cs = 1'b0; ad0_cs = 1'b0; ad1_cs = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // CPU miss, slot latency 2
        @(negedge clk);
        lat = 2;
        cpu_addr = 15'h1234; cpu_cs = 1'b1;
        exp_q.push_back(18'h01234);
        repeat (3) @(posedge clk);
        #1 check("cpu_ok_early", cpu_ok, 0);
        @(posedge clk);
        #1 check("cpu_ok_lat4", cpu_ok, 1);
        check("cpu_data", cpu_data, 8'hA5);
        g0 = grants;
        repeat (6) @(negedge clk);
        #1 check("cpu_no_rereq", grants, g0);
        check("cpu_ok_held", cpu_ok, 1);

        // AD1 at top of range, minimum latency, then a cached hit
        @(negedge clk);
        cpu_cs = 1'b0;
        lat = 1;
        ad1_addr = 16'hFFFF; ad1_cs = 1'b1;
        exp_q.push_back(18'h27FFF);
        repeat (2) @(posedge clk);
        #1 check("ad1_ok_early", ad1_ok, 0);
        @(posedge clk);
        #1 check("ad1_ok_lat3", ad1_ok, 1);
        check("ad1_data", ad1_data, dm(18'h27FFF));
        @(negedge clk);
        ad1_cs = 1'b0;
        #1 check("ad1_ok_cs_low", ad1_ok, 0);
        g0 = grants;
        @(negedge clk);
        ad1_cs = 1'b1;
        #1 check("ad1_hit", ad1_ok, 1);
        repeat (4) @(negedge clk);
        #1 check("ad1_hit_no_req", grants, g0);
        ad1_cs = 1'b0;

        // simultaneous requests: CPU, AD0, AD1
        @(negedge clk);
        lat = 2;
        cpu_addr = 15'h0100; ad0_addr = 16'h0200; ad1_addr = 16'h0300;
        cpu_cs = 1'b1; ad0_cs = 1'b1; ad1_cs = 1'b1;
        exp_q.push_back(18'h00100);
        exp_q.push_back(18'h08200);
        exp_q.push_back(18'h18300);
        wait_ok(0, "all_cpu_ok");
        wait_ok(1, "all_ad0_ok");
        wait_ok(2, "all_ad1_ok");
        check("all_cpu_data", cpu_data, dm(18'h00100));
        check("all_ad0_data", ad0_data, dm(18'h08200));
        check("all_ad1_data", ad1_data, dm(18'h18300));
        cpu_cs = 1'b0; ad0_cs = 1'b0; ad1_cs = 1'b0;
        repeat (4) @(negedge clk);

        // both ADPCM channels continuously missing
`ifdef JTDD_SNDARB_RR_EN
        exp_q.push_back(18'h08400);
        exp_q.push_back(18'h18500);
        exp_q.push_back(18'h08401);
        exp_q.push_back(18'h18501);
`else
        exp_q.push_back(18'h08400);
        exp_q.push_back(18'h08401);
        exp_q.push_back(18'h08402);
        exp_q.push_back(18'h08403);
`endif
        g0 = grants;
        ad0_addr = 16'h0400; ad1_addr = 16'h0500;
        ad0_cs = 1'b1; ad1_cs = 1'b1;
        for (int n = 0; n < 300 && grants < g0 + 4; n++) begin
            @(negedge clk); #1;
            if (ad0_ok) ad0_addr = ad0_addr + 16'd1;
            if (ad1_ok) ad1_addr = ad1_addr + 16'd1;
        end
        ad0_cs = 1'b0; ad1_cs = 1'b0;
        check("adpcm_grants", grants - g0, 4);
        repeat (8) @(negedge clk);

        // address change while BUSY
        lat = 3;
        g0 = grants;
        f0 = fills;
        ad0_addr = 16'h0010; ad0_cs = 1'b1;
        exp_q.push_back(18'h08010);
        exp_q.push_back(18'h08011);
        wait_grant(g0 + 1);
        ad0_addr = 16'h0011;
        wait_fill(f0 + 1);
        @(negedge clk);
        #1 check("ad0_stale_ok", ad0_ok, 0);
        wait_ok(1, "ad0_refetch_ok");
        check("ad0_refetch_data", ad0_data, dm(18'h08011));
        check("idle_gap", last_gap, 1);
        ad0_cs = 1'b0;
        repeat (3) @(negedge clk);

        // reset while BUSY, then late and spurious slot_ok
        resp_en = 1'b0;
        g0 = grants;
        cpu_addr = 15'h0777; cpu_cs = 1'b1;
        exp_q.push_back(18'h00777);
        wait_grant(g0 + 1);
        rst_n = 1'b0;
        #1 check("rst_async_req", slot_req, 0);
        check("rst_async_addr", slot_addr, 0);
        cpu_addr = 15'h0100;
        ad0_addr = 16'h0011; ad0_cs = 1'b1;
        #1 check("rst_cpu_invalid", cpu_ok, 0);
        check("rst_ad0_invalid", ad0_ok, 0);
        man_req++;
        repeat (2) @(negedge clk);
        cpu_cs = 1'b0; ad0_cs = 1'b0;
        rst_n = 1'b1;
        g0 = grants;
        @(negedge clk);
        #1 man_req++;
        repeat (2) @(negedge clk);
        #1 check("spur_no_req", slot_req, 0);
        check("spur_no_grant", grants, g0);
        check("spur_cpu_data", cpu_data, 0);
        cpu_addr = 15'h0777; cpu_cs = 1'b1;
        #1 check("spur_cpu_ok", cpu_ok, 0);
        resp_en = 1'b1;
        lat = 2;
        exp_q.push_back(18'h00777);
        wait_ok(0, "post_rst_cpu_ok");
        check("post_rst_cpu_data", cpu_data, dm(18'h00777));
        cpu_cs = 1'b0;
        repeat (3) @(negedge clk);

        check("sb_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
